// File: rtl/rxfifo_param_if.sv
// rxfifo_param_if: bundles the receive-FIFO data/strobe/status signals.
//   master: write side and host side drivers (din, din_err, we, host_rd,
//           flush, ovr_clr) and observers of head data and status.
//   slave : the FIFO itself.
// WIDTH/DEPTH must match the FIFO instance; CNTW is derived here the same
// way the FIFO derives it.
interface rxfifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] din;
  logic             din_err;
  logic             we;
  logic             host_rd;
  logic             flush;
  logic             ovr_clr;
  logic [WIDTH-1:0] host_dout;
  logic             host_err;
  logic             host_dor;
  logic             dir;
  logic             almost_full;
  logic [CNTW-1:0]  count;
  logic             overrun;

  modport master (
    output din, din_err, we, host_rd, flush, ovr_clr,
    input  host_dout, host_err, host_dor, dir, almost_full, count, overrun
  );

  modport slave (
    input  din, din_err, we, host_rd, flush, ovr_clr,
    output host_dout, host_err, host_dor, dir, almost_full, count, overrun
  );
endinterface

// File: rtl/rxfifo_param.sv
// rxfifo_param: parametrised receive FIFO between the UART receive shift
// register and the host read port. Each entry holds {err_tag, data}.
// Ports:
//   clk   - single clock; all state changes on the falling edge.
//   reset - synchronous, active-high; same effect as flush.
//   bus   - rxfifo_param_if.slave: din/din_err/we write side, host_rd pop,
//           flush, ovr_clr; host_dout/host_err head (fall-through),
//           host_dor (not empty), dir (not full), almost_full, count,
//           sticky overrun.
module rxfifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int CNTW     = $clog2(DEPTH + 1)
) (
  input logic           clk,
  input logic           reset,
  rxfifo_param_if.slave bus
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] CNT_AF   = CNTW'(AF_LEVEL);

  logic [WIDTH:0]    mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              wr_acc, rd_acc, wr_drop, clear;

  always_comb begin
    clear   = reset || bus.flush;
    wr_acc  = !clear && bus.we && (count_q < CNT_FULL);
    rd_acc  = !clear && bus.host_rd && (count_q != '0);
    // A write on a full FIFO is lost even if a read frees a slot this edge.
    wr_drop = !clear && bus.we && (count_q == CNT_FULL);

    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (clear) begin
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else begin
      // Explicit wrap so non-power-of-two depths work.
      if (wr_acc) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
      if (rd_acc) rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
      if (wr_drop)          overrun_d = 1'b1;
      else if (bus.ovr_clr) overrun_d = 1'b0;
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage has no reset; contents are don't-care after reset/flush.
  always_ff @(negedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= {bus.din_err, bus.din};
  end

  always_comb begin
    bus.host_dout   = mem_q[rptr_q][WIDTH-1:0];
    bus.host_err    = mem_q[rptr_q][WIDTH];
    bus.host_dor    = (count_q != '0);
    bus.dir         = (count_q < CNT_FULL);
    bus.almost_full = (count_q >= CNT_AF);
    bus.count       = count_q;
    bus.overrun     = overrun_q;
  end

endmodule

// File: tb/tb_rxfifo_param.sv
module tb_rxfifo_param;

  logic clk = 1'b1;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  rxfifo_param_if #(.WIDTH(8), .DEPTH(16)) a_if ();
  rxfifo_param_if #(.WIDTH(8), .DEPTH(5))  b_if ();

  rxfifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14)) u_a (
    .clk(clk), .reset(rst), .bus(a_if.slave)
  );
  rxfifo_param #(.WIDTH(8), .DEPTH(5)) u_b (
    .clk(clk), .reset(rst), .bus(b_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // One falling edge on instance A with the given inputs, then idle inputs.
  task automatic a_step(input logic w, input logic [7:0] d, input logic e,
                        input logic r, input logic f, input logic oc);
    a_if.we = w; a_if.din = d; a_if.din_err = e;
    a_if.host_rd = r; a_if.flush = f; a_if.ovr_clr = oc;
    @(negedge clk); #1;
    a_if.we = 1'b0; a_if.host_rd = 1'b0; a_if.flush = 1'b0; a_if.ovr_clr = 1'b0;
  endtask

  task automatic b_step(input logic w, input logic [7:0] d, input logic e, input logic r);
    b_if.we = w; b_if.din = d; b_if.din_err = e; b_if.host_rd = r;
    @(negedge clk); #1;
    b_if.we = 1'b0; b_if.host_rd = 1'b0;
  endtask

  task automatic a_status(input string tag, input int cnt, input logic ovr);
    check({tag, ".count"}, a_if.count, cnt);
    check({tag, ".dor"},   a_if.host_dor, (cnt > 0));
    check({tag, ".dir"},   a_if.dir, (cnt < 16));
    check({tag, ".af"},    a_if.almost_full, (cnt >= 14));
    check({tag, ".ovr"},   a_if.overrun, ovr);
  endtask

  // Leave A at count 7 with overrun set.
  task automatic a_build_ovr7();
    for (int i = 0; i < 16; i++) a_step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    a_step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) a_step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    a_status("pre7", 7, 1'b1);
    check("pre7.head", a_if.host_dout, 8'h69);
  endtask

  initial begin
    a_if.din = '0; a_if.din_err = 1'b0; a_if.we = 1'b0;
    a_if.host_rd = 1'b0; a_if.flush = 1'b0; a_if.ovr_clr = 1'b0;
    b_if.din = '0; b_if.din_err = 1'b0; b_if.we = 1'b0;
    b_if.host_rd = 1'b0; b_if.flush = 1'b0; b_if.ovr_clr = 1'b0;

    rst = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b0;
    a_status("rst", 0, 1'b0);
    check("b_rst.count", b_if.count, 0);
    check("b_rst.dir",   b_if.dir, 1);
    check("b_rst.af",    b_if.almost_full, 0);

    // Fill A with 0x00..0x0F, error tag on odd values.
    for (int i = 0; i < 16; i++) begin
      a_step(1'b1, 8'(i), i[0], 1'b0, 1'b0, 1'b0);
      a_status($sformatf("fill%0d", i), i + 1, 1'b0);
      if (i == 0) begin
        check("fwft.dout", a_if.host_dout, 8'h00);
        check("fwft.err",  a_if.host_err, 1'b0);
      end
    end
    // Drain in order.
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d.dout", i), a_if.host_dout, i);
      check($sformatf("drain%0d.err", i),  a_if.host_err, i & 1);
      a_step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    a_status("drained", 0, 1'b0);

    // Overrun: full FIFO, write 0xAA with a read on the same edge.
    for (int i = 0; i < 16; i++) a_step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    a_status("refill", 16, 1'b0);
    a_step(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0);
    a_status("ovr", 15, 1'b1);
    check("ovr.head", a_if.host_dout, 8'h11);
    a_step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    a_status("ovrclr", 15, 1'b0);
    a_step(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    a_status("full2", 16, 1'b0);
    // Dropped write and clear on one edge: set wins.
    a_step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b1);
    a_status("setwins", 16, 1'b1);
    a_step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr2.ovr", a_if.overrun, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain2_%0d", i), a_if.host_dout, 8'h11 + i);
      a_step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    a_status("drained2", 0, 1'b0);

    // Read on empty is ignored.
    a_step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    a_status("rdempty", 0, 1'b0);

    // Simultaneous read and write at count 1.
    a_step(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    a_step(1'b1, 8'h31, 1'b1, 1'b1, 1'b0, 1'b0);
    a_status("rw1", 1, 1'b0);
    check("rw1.dout", a_if.host_dout, 8'h31);
    check("rw1.err",  a_if.host_err, 1'b1);
    a_step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    a_status("rw1.empty", 0, 1'b0);

    // DEPTH=5 wrap-around: count alternates 3/2 through 23 pairs.
    b_step(1'b1, 8'h80, 1'b0, 1'b0);
    b_step(1'b1, 8'h81, 1'b1, 1'b0);
    check("b.pre.count", b_if.count, 2);
    for (int k = 0; k < 23; k++) begin
      b_step(1'b1, 8'(8'h82 + k), k[0], 1'b0);
      check($sformatf("b%0d.wcount", k), b_if.count, 3);
      check($sformatf("b%0d.af", k), b_if.almost_full, 1'b1);
      check($sformatf("b%0d.dout", k), b_if.host_dout, 8'h80 + k);
      check($sformatf("b%0d.err", k),  b_if.host_err, k & 1);
      b_step(1'b0, 8'h00, 1'b0, 1'b1);
      check($sformatf("b%0d.rcount", k), b_if.count, 2);
    end

    // Flush overrides a same-edge write, read and state.
    a_build_ovr7();
    a_step(1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 1'b0);
    a_status("flush", 0, 1'b0);
    a_step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    check("flush.next", a_if.host_dout, 8'h55);
    check("flush.cnt1", a_if.count, 1);
    a_step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Same scenario with reset.
    a_build_ovr7();
    rst = 1'b1;
    a_step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    a_status("reset", 0, 1'b0);
    a_step(1'b1, 8'h56, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset.next", a_if.host_dout, 8'h56);
    check("reset.cnt1", a_if.count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
